// File: rtl/col_decoder_3b_if.sv
// col_decoder_3b_if: bundles the packet input, the pixel stream and the side
// outputs of the column decoder.
//   encoded_dat/data_ready          : packet word and its single-cycle qualifier
//   pixel_out/valid/ready/gap       : decoded 3-bit pixel stream (valid/ready)
//   ts_out/ts_valid                 : resurrection timestamp report
//   alarm_ts/alarm_valid            : alarm timer bits report
//   frame_err, overflow             : error pulse / sticky drop flag
// slave = decoder side, master = link/consumer side.
interface col_decoder_3b_if;
    logic [15:0] encoded_dat;
    logic        data_ready;
    logic [2:0]  pixel_out;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        pixel_gap;
    logic [31:0] ts_out;
    logic        ts_valid;
    logic [14:0] alarm_ts;
    logic        alarm_valid;
    logic        frame_err;
    logic        overflow;

    modport slave (
        input  encoded_dat, data_ready, pixel_ready,
        output pixel_out, pixel_valid, pixel_gap, ts_out, ts_valid,
               alarm_ts, alarm_valid, frame_err, overflow
    );

    modport master (
        output encoded_dat, data_ready, pixel_ready,
        input  pixel_out, pixel_valid, pixel_gap, ts_out, ts_valid,
               alarm_ts, alarm_valid, frame_err, overflow
    );
endinterface

// File: rtl/col_decoder_3b.sv
// col_decoder_3b: receive side of the 3-bit column link. Parses RAW, MARKER+TS
// and ALARM packets, buffers RAW packets in a small FIFO and serializes each
// into five 3-bit pixels on a valid/ready stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : col_decoder_3b_if.slave (packet in, pixel out, side reports)
module col_decoder_3b #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    col_decoder_3b_if.slave  bus
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] MARKER  = 16'h8000;
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {PARSE, TS_HI, TS_LO} state_t;

    state_t      state;
    logic        gap_pending;
    logic [15:0] ts_hi;
    logic [31:0] ts_out_q;
    logic        ts_valid_q;
    logic [14:0] alarm_ts_q;
    logic        alarm_valid_q;
    logic        frame_err_q;
    logic        overflow_q;

    logic [FIFO_DEPTH-1:0][15:0] fifo_mem;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty;
    logic        push_req, push, pop;

    logic [15:0] ent;        // {gap tag, five pixels}
    logic        ent_vld;
    logic [2:0]  idx;
    logic [2:0]  cur_pix;
    logic        adv, ent_take, ent_free;
    logic [2:0]  pix_q;
    logic        pix_vld_q, gap_q;

    wire [15:0] dat = bus.encoded_dat;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push_req = (state == PARSE) && bus.data_ready && !dat[15];
    // A full FIFO still accepts when the serializer drains the head this cycle.
    assign push     = push_req && (!fifo_full || pop);

    // Output register advances whenever it is empty or being accepted.
    assign adv      = !pix_vld_q || bus.pixel_ready;
    assign ent_take = ent_vld && adv;
    assign ent_free = !ent_vld || (ent_take && idx == 3'd4);
    assign pop      = ent_free && !fifo_empty;

    always_comb begin
        cur_pix = ent[14:12];
        case (idx)
            3'd1:    cur_pix = ent[11:9];
            3'd2:    cur_pix = ent[8:6];
            3'd3:    cur_pix = ent[5:3];
            3'd4:    cur_pix = ent[2:0];
            default: cur_pix = ent[14:12];
        endcase
    end

    // Parser FSM with registered side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= PARSE;
            gap_pending   <= 1'b0;
            ts_hi         <= '0;
            ts_out_q      <= '0;
            ts_valid_q    <= 1'b0;
            alarm_ts_q    <= '0;
            alarm_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            ts_valid_q    <= 1'b0;
            alarm_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (state)
                PARSE: begin
                    if (bus.data_ready) begin
                        if (!dat[15]) begin
                            // A dropped packet leaves the gap tag for the next one.
                            if (push) gap_pending <= 1'b0;
                            else      overflow_q  <= 1'b1;
                        end else if (dat == MARKER) begin
                            state <= TS_HI;
                        end else begin
                            alarm_ts_q    <= dat[14:0];
                            alarm_valid_q <= 1'b1;
                        end
                    end
                end
                TS_HI: begin
                    if (bus.data_ready) begin
                        ts_hi <= dat;
                        state <= TS_LO;
                    end else begin
                        frame_err_q <= 1'b1;
                        state       <= PARSE;
                    end
                end
                TS_LO: begin
                    if (bus.data_ready) begin
                        ts_out_q    <= {ts_hi, dat};
                        ts_valid_q  <= 1'b1;
                        gap_pending <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state <= PARSE;
                end
                default: state <= PARSE;
            endcase
        end
    end

    // FIFO storage carries no reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {gap_pending, dat[14:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Serializer: entry register feeds the registered pixel output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent       <= '0;
            ent_vld   <= 1'b0;
            idx       <= '0;
            pix_q     <= '0;
            pix_vld_q <= 1'b0;
            gap_q     <= 1'b0;
        end else begin
            if (adv) begin
                pix_vld_q <= ent_vld;
                if (ent_vld) begin
                    pix_q <= cur_pix;
                    gap_q <= ent[15] && (idx == 3'd0);
                end
            end
            if (pop) begin
                ent     <= fifo_mem[rd_ptr[AW-1:0]];
                ent_vld <= 1'b1;
                idx     <= '0;
            end else if (ent_take) begin
                if (idx == 3'd4) ent_vld <= 1'b0;
                else             idx     <= idx + 3'd1;
            end
        end
    end

    assign bus.pixel_out   = pix_q;
    assign bus.pixel_valid = pix_vld_q;
    assign bus.pixel_gap   = gap_q;
    assign bus.ts_out      = ts_out_q;
    assign bus.ts_valid    = ts_valid_q;
    assign bus.alarm_ts    = alarm_ts_q;
    assign bus.alarm_valid = alarm_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_col_decoder_3b.sv
module tb_col_decoder_3b;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    col_decoder_3b_if bus();

    col_decoder_3b #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model: expected pixel stream as {gap, pixel}, expected
    // side-report events, and the pending-gap flag set by a timestamp.
    logic [3:0]  exp_pix[$];
    logic [31:0] exp_ts[$];
    logic [14:0] exp_al[$];
    int          exp_fe = 0;
    bit          model_gap = 1'b0;

    logic [3:0]  seen[$];
    int          seen_cyc[$];

    int          ready_mode = 0; // 0 low, 1 high, 2 random
    bit          prev_stall = 1'b0;
    logic [3:0]  prev_out;
    logic [3:0]  cmp_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // pixel_ready driver; the only writer of pixel_ready.
    initial begin
        bus.pixel_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       bus.pixel_ready = 1'b1;
                2:       bus.pixel_ready = ($urandom_range(0, 3) != 0);
                default: bus.pixel_ready = 1'b0;
            endcase
        end
    end

    // Compare process: every accepted pixel and every side pulse vs the model.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (prev_stall)
                chk("stall_hold", {bus.pixel_valid, bus.pixel_gap, bus.pixel_out}, {1'b1, prev_out});
            if (bus.pixel_valid && bus.pixel_ready) begin
                if (exp_pix.size() == 0) begin
                    fail("unexpected_pixel");
                end else begin
                    cmp_e = exp_pix.pop_front();
                    chk("pixel", {bus.pixel_gap, bus.pixel_out}, cmp_e);
                end
                seen.push_back({bus.pixel_gap, bus.pixel_out});
                seen_cyc.push_back(cyc);
            end
            prev_stall = bus.pixel_valid && !bus.pixel_ready;
            prev_out   = {bus.pixel_gap, bus.pixel_out};
            if (bus.ts_valid) begin
                if (exp_ts.size() == 0) fail("unexpected_ts_valid");
                else chk("ts_out", bus.ts_out, exp_ts.pop_front());
            end
            if (bus.alarm_valid) begin
                if (exp_al.size() == 0) fail("unexpected_alarm_valid");
                else chk("alarm_ts", bus.alarm_ts, exp_al.pop_front());
            end
            if (bus.frame_err) begin
                if (exp_fe == 0) fail("unexpected_frame_err");
                else begin
                    checks++;
                    exp_fe--;
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // One input cycle; entered and left 1ns after a rising edge.
    task automatic cycle(input logic [15:0] w, input logic dr);
        bus.encoded_dat = w;
        bus.data_ready  = dr;
        @(posedge clk);
        #1;
        bus.data_ready  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(16'h0000, 1'b0);
    endtask

    task automatic send_raw(input logic [14:0] d, input bit keep);
        if (keep) begin
            for (int i = 0; i < 5; i++)
                exp_pix.push_back({(i == 0) ? model_gap : 1'b0, 3'((d >> (12 - 3 * i)) & 15'h7)});
            model_gap = 1'b0;
        end
        cycle({1'b0, d}, 1'b1);
    endtask

    task automatic send_ts(input logic [31:0] ts);
        exp_ts.push_back(ts);
        cycle(16'h8000, 1'b1);
        cycle(ts[31:16], 1'b1);
        cycle(ts[15:0], 1'b1);
        model_gap = 1'b1;
    endtask

    task automatic send_alarm(input logic [15:0] w);
        exp_al.push_back(w[14:0]);
        cycle(w, 1'b1);
    endtask

    task automatic send_broken(input bit with_hi);
        exp_fe++;
        cycle(16'h8000, 1'b1);
        if (with_hi) cycle(16'($urandom), 1'b1);
        cycle(16'h0000, 1'b0);
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        ready_mode = 1;
        while (exp_pix.size() != 0 && b < budget) begin
            idle(1);
            b++;
        end
        if (b >= budget) fail("drain_timeout");
        idle(3);
    endtask

    task automatic check_seen(input string nm, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d, input logic [3:0] e);
        logic [3:0] lit[5];
        lit[0] = a; lit[1] = b; lit[2] = c; lit[3] = d; lit[4] = e;
        chk({nm, "_count"}, seen.size(), 5);
        if (seen.size() == 5)
            for (int i = 0; i < 5; i++) chk(nm, seen[i], lit[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] pk[DEPTH + 2];
        int r;
        int b;

        bus.encoded_dat = '0;
        bus.data_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pixel_valid", bus.pixel_valid, 0);
        chk("rst_ts_out", bus.ts_out, 0);
        chk("rst_flags", {bus.ts_valid, bus.alarm_valid, bus.frame_err, bus.overflow, bus.pixel_gap}, 0);
        rst_n = 1'b1;
        ready_mode = 1;
        idle(2);

        // RAW 0A72: latency and pixel order.
        seen.delete();
        seen_cyc.delete();
        send_raw(15'h0A72, 1'b1);
        chk("lat_e0", bus.pixel_valid, 0);
        idle(1);
        chk("lat_e1", bus.pixel_valid, 0);
        idle(1);
        chk("lat_e2", bus.pixel_valid, 1);
        drain(50);
        check_seen("raw_0a72", 4'd0, 4'd5, 4'd1, 4'd6, 4'd2);
        if (seen_cyc.size() == 5) chk("raw_consecutive", seen_cyc[4] - seen_cyc[0], 4);

        // Timestamp then RAW 0001: gap only on first pixel.
        seen.delete();
        send_ts(32'h12345678);
        chk("ts_pulse", bus.ts_valid, 1);
        chk("ts_value", bus.ts_out, 32'h12345678);
        send_raw(15'h0001, 1'b1);
        chk("ts_one_pulse", bus.ts_valid, 0);
        drain(50);
        check_seen("gap_raw", 4'h8, 4'h0, 4'h0, 4'h0, 4'h1);

        // Alarm: report only, no pixels.
        seen.delete();
        send_alarm(16'hC003);
        chk("alarm_pulse", bus.alarm_valid, 1);
        chk("alarm_value", bus.alarm_ts, 15'h4003);
        idle(1);
        chk("alarm_one_pulse", bus.alarm_valid, 0);
        idle(6);
        chk("alarm_no_pixels", seen.size(), 0);

        // Broken timestamp, then RAW 7FFF.
        seen.delete();
        send_broken(1'b0);
        chk("frame_err_pulse", bus.frame_err, 1);
        chk("frame_err_ts_kept", bus.ts_out, 32'h12345678);
        send_raw(15'h7FFF, 1'b1);
        chk("frame_err_one_pulse", bus.frame_err, 0);
        drain(50);
        check_seen("raw_7fff", 4'd7, 4'd7, 4'd7, 4'd7, 4'd7);

        // Overflow: DEPTH+2 packets with pixel_ready low, last one dropped.
        ready_mode = 0;
        idle(2);
        seen.delete();
        for (int k = 0; k < DEPTH + 2; k++) pk[k] = 15'($urandom);
        for (int k = 0; k < DEPTH + 2; k++) send_raw(pk[k], k <= DEPTH);
        idle(4);
        chk("overflow_set", bus.overflow, 1);
        chk("overflow_hold_first", {bus.pixel_valid, bus.pixel_out}, {1'b1, pk[0][14:12]});
        drain(200);
        chk("overflow_pixel_count", seen.size(), (DEPTH + 1) * 5);
        chk("overflow_sticky", bus.overflow, 1);

        // Reset during serialization.
        send_raw(15'h2AAA, 1'b1);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_pixel", {bus.pixel_valid, bus.pixel_out, bus.pixel_gap}, 0);
        chk("midrst_flags", {bus.overflow, bus.ts_valid, bus.alarm_valid, bus.frame_err}, 0);
        chk("midrst_ts", bus.ts_out, 0);
        exp_pix.delete();
        exp_ts.delete();
        exp_al.delete();
        exp_fe = 0;
        model_gap = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        seen.delete();
        send_raw(15'h4C2F, 1'b1);
        drain(50);
        check_seen("post_rst", 4'd4, 4'd6, 4'd0, 4'd5, 4'd7);

        // Randomized mixed traffic with random backpressure.
        ready_mode = 2;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                b = 0;
                while (exp_pix.size() > 10 && b < 500) begin
                    idle(1);
                    b++;
                end
                if (b >= 500) fail("backlog_timeout");
                send_raw(15'($urandom), 1'b1);
            end else if (r < 75) begin
                send_ts($urandom);
            end else if (r < 90) begin
                send_alarm({1'b1, 15'($urandom_range(1, 32767))});
            end else begin
                send_broken(1'($urandom_range(0, 1)));
            end
            idle($urandom_range(0, 2));
        end
        drain(2000);
        chk("end_ts_pending", exp_ts.size(), 0);
        chk("end_alarm_pending", exp_al.size(), 0);
        chk("end_fe_pending", exp_fe, 0);
        chk("end_overflow", bus.overflow, 0);
        chk("end_pixel_valid", bus.pixel_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
